axi4lite_slave_regs: RTL and testbench

- AXI4-Lite responder (slave endpoint) terminating transactions issued by the core-side AXI4-Lite master.
- Holds a bank of NUM_REGS memory-mapped registers with byte-strobe writes.
- Returns OKAY or SLVERR per access.
- Exposes register contents and per-register write pulses to local control logic.

---
 rtl/axi4lite_pkg.sv | 18 +
 rtl/axi4lite_regbank.sv | 51 +++++
 rtl/axi4lite_slave_regs.sv | 210 +++++++++++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite
// register slave.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

endpackage

// File: rtl/axi4lite_regbank.sv
// Register array with byte-strobe write port, combinational read port,
// flattened contents and registered per-register write pulses.
module axi4lite_regbank #(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic [IDX_W-1:0]               widx_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [STRB_WIDTH-1:0]          wstrb_i,
    input  logic [IDX_W-1:0]               ridx_i,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 pulse_q, pulse_d;

    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        if (we_i) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb_i[b]) begin
                    regs_d[widx_i][b*8 +: 8] = wdata_i[b*8 +: 8];
                end
            end
            pulse_d[widx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q  <= '0;
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    assign rdata_o    = regs_q[ridx_i];
    assign regs_o     = regs_q;
    assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave terminating reads and writes into a bank of
// memory-mapped registers, with independent read and write FSMs.
module axi4lite_slave_regs
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                           axi_clk,
    input  logic                           axi_arst,
    input  logic [ADDR_WIDTH-1:0]          saxi_awaddr,
    input  logic [2:0]                     saxi_awprot,
    input  logic                           saxi_awvalid,
    output logic                           saxi_awready,
    input  logic [DATA_WIDTH-1:0]          saxi_wdata,
    input  logic [STRB_WIDTH-1:0]          saxi_wstrb,
    input  logic                           saxi_wvalid,
    output logic                           saxi_wready,
    output logic [1:0]                     saxi_bresp,
    output logic                           saxi_bvalid,
    input  logic                           saxi_bready,
    input  logic [ADDR_WIDTH-1:0]          saxi_araddr,
    input  logic [2:0]                     saxi_arprot,
    input  logic                           saxi_arvalid,
    output logic                           saxi_arready,
    output logic [DATA_WIDTH-1:0]          saxi_rdata,
    output logic [1:0]                     saxi_rresp,
    output logic                           saxi_rvalid,
    input  logic                           saxi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int TAG_LSB  = ADDR_LSB + IDX_W;

    // Address hits only when every bit above the index field is zero.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:TAG_LSB] == '0;
    endfunction

    wstate_e                 w_state_q, w_state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
    logic                    aw_hit_q, aw_hit_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;

    rstate_e                 r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rvalid_q, rvalid_d;

    logic                    aw_hs, w_hs;
    logic                    wr_en, wr_hit;
    logic [IDX_W-1:0]        wr_idx;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [STRB_WIDTH-1:0]   wr_strb;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    unused_bits;

    assign unused_bits = ^{saxi_awprot, saxi_arprot,
                           saxi_awaddr[ADDR_LSB-1:0],
                           saxi_araddr[ADDR_LSB-1:0]};

    // Held copies take priority over the live channel once captured.
    assign wr_idx  = aw_held_q ? aw_idx_q : saxi_awaddr[ADDR_LSB +: IDX_W];
    assign wr_hit  = aw_held_q ? aw_hit_q : addr_hit(saxi_awaddr);
    assign wr_data = w_held_q ? wdata_q : saxi_wdata;
    assign wr_strb = w_held_q ? wstrb_q : saxi_wstrb;
    assign rd_idx  = saxi_araddr[ADDR_LSB +: IDX_W];

    always_comb begin
        w_state_d    = w_state_q;
        aw_held_d    = aw_held_q;
        w_held_d     = w_held_q;
        aw_idx_d     = aw_idx_q;
        aw_hit_d     = aw_hit_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        saxi_awready = 1'b0;
        saxi_wready  = 1'b0;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;
        wr_en        = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                saxi_awready = ~aw_held_q;
                saxi_wready  = ~w_held_q;
                aw_hs        = saxi_awvalid & ~aw_held_q;
                w_hs         = saxi_wvalid & ~w_held_q;
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = saxi_awaddr[ADDR_LSB +: IDX_W];
                    aw_hit_d  = addr_hit(saxi_awaddr);
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = saxi_wdata;
                    wstrb_d  = saxi_wstrb;
                end
                if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
                    wr_en     = wr_hit;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (saxi_bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        r_state_d    = r_state_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        rvalid_d     = rvalid_q;
        saxi_arready = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                saxi_arready = 1'b1;
                if (saxi_arvalid) begin
                    rvalid_d  = 1'b1;
                    rresp_d   = addr_hit(saxi_araddr) ? RESP_OKAY : RESP_SLVERR;
                    rdata_d   = addr_hit(saxi_araddr) ? rd_data : '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (saxi_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_arst) begin
        if (axi_arst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            aw_hit_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            aw_hit_q  <= aw_hit_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign saxi_bvalid = bvalid_q;
    assign saxi_bresp  = bresp_q;
    assign saxi_rvalid = rvalid_q;
    assign saxi_rresp  = rresp_q;
    assign saxi_rdata  = rdata_q;

    axi4lite_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regbank (
        .clk_i      (axi_clk),
        .rst_i      (axi_arst),
        .we_i       (wr_en),
        .widx_i     (wr_idx),
        .wdata_i    (wr_data),
        .wstrb_i    (wr_strb),
        .ridx_i     (rd_idx),
        .rdata_o    (rd_data),
        .regs_o     (reg_out),
        .wr_pulse_o (reg_wr_pulse)
    );

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs with a queue-based response
// scoreboard and inline register/pulse checks.
module tb_axi4lite_slave_regs;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int NR = 16;

    logic              axi_clk = 1'b0;
    logic              axi_arst = 1'b1;
    logic [AW-1:0]     saxi_awaddr = '0;
    logic [2:0]        saxi_awprot = '0;
    logic              saxi_awvalid = 1'b0;
    logic              saxi_awready;
    logic [DW-1:0]     saxi_wdata = '0;
    logic [SW-1:0]     saxi_wstrb = '0;
    logic              saxi_wvalid = 1'b0;
    logic              saxi_wready;
    logic [1:0]        saxi_bresp;
    logic              saxi_bvalid;
    logic              saxi_bready = 1'b0;
    logic [AW-1:0]     saxi_araddr = '0;
    logic [2:0]        saxi_arprot = '0;
    logic              saxi_arvalid = 1'b0;
    logic              saxi_arready;
    logic [DW-1:0]     saxi_rdata;
    logic [1:0]        saxi_rresp;
    logic              saxi_rvalid;
    logic              saxi_rready = 1'b0;
    logic [NR*DW-1:0]  reg_out;
    logic [NR-1:0]     reg_wr_pulse;

    always #5 axi_clk = ~axi_clk;

    axi4lite_slave_regs dut (
        .axi_clk      (axi_clk),
        .axi_arst     (axi_arst),
        .saxi_awaddr  (saxi_awaddr),
        .saxi_awprot  (saxi_awprot),
        .saxi_awvalid (saxi_awvalid),
        .saxi_awready (saxi_awready),
        .saxi_wdata   (saxi_wdata),
        .saxi_wstrb   (saxi_wstrb),
        .saxi_wvalid  (saxi_wvalid),
        .saxi_wready  (saxi_wready),
        .saxi_bresp   (saxi_bresp),
        .saxi_bvalid  (saxi_bvalid),
        .saxi_bready  (saxi_bready),
        .saxi_araddr  (saxi_araddr),
        .saxi_arprot  (saxi_arprot),
        .saxi_arvalid (saxi_arvalid),
        .saxi_arready (saxi_arready),
        .saxi_rdata   (saxi_rdata),
        .saxi_rresp   (saxi_rresp),
        .saxi_rvalid  (saxi_rvalid),
        .saxi_rready  (saxi_rready),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    typedef struct {
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } rexp_t;

    logic [1:0] bq[$];
    rexp_t      rq[$];
    logic [1:0] b_exp;
    rexp_t      r_exp;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name, input logic [NR*DW-1:0] exp);
        checks++;
        if (reg_out !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, reg_out, exp);
        end
    endtask

    function automatic logic [DW-1:0] reg_of(input int i);
        return reg_out[i*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // Monitor: a valid with its ready seen here completes at the next edge.
    always @(negedge axi_clk) begin
        if (!axi_arst) begin
            if (saxi_bvalid && saxi_bready) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected actual=%b required=none",
                             saxi_bresp);
                end else begin
                    b_exp = bq.pop_front();
                    chk("bresp", 64'(saxi_bresp), 64'(b_exp));
                end
            end
            if (saxi_rvalid && saxi_rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected actual=%b required=none",
                             saxi_rresp);
                end else begin
                    r_exp = rq.pop_front();
                    chk("rresp", 64'(saxi_rresp), 64'(r_exp.resp));
                    chk("rdata", saxi_rdata, r_exp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [NR*DW-1:0] snap;

    initial begin
        repeat (2) @(posedge axi_clk);
        #1;
        chk("rst_bvalid", 64'(saxi_bvalid), 64'h0);
        chk("rst_rvalid", 64'(saxi_rvalid), 64'h0);
        chk("rst_rdata", saxi_rdata, 64'h0);
        chk("rst_pulse", 64'(reg_wr_pulse), 64'h0);
        chk_regs("rst_regs", '0);
        axi_arst = 1'b0;
        tick();
        chk("idle_awready", 64'(saxi_awready), 64'h1);
        chk("idle_wready", 64'(saxi_wready), 64'h1);
        chk("idle_arready", 64'(saxi_arready), 64'h1);

        // AW and W together
        saxi_awaddr = 64'h08;
        saxi_awvalid = 1'b1;
        saxi_wdata = 64'h1122334455667788;
        saxi_wstrb = 8'hFF;
        saxi_wvalid = 1'b1;
        bq.push_back(2'b00);
        tick();
        saxi_awvalid = 1'b0;
        saxi_wvalid = 1'b0;
        chk("t1_bvalid", 64'(saxi_bvalid), 64'h1);
        chk("t1_pulse", 64'(reg_wr_pulse), 64'h0002);
        chk("t1_reg1", reg_of(1), 64'h1122334455667788);
        tick();
        chk("t1_pulse_off", 64'(reg_wr_pulse), 64'h0);
        chk("t1_bvalid_hold", 64'(saxi_bvalid), 64'h1);
        saxi_bready = 1'b1;
        tick();
        saxi_bready = 1'b0;
        chk("t1_bvalid_drop", 64'(saxi_bvalid), 64'h0);

        // W three cycles ahead of AW
        saxi_wdata = 64'hFFFFFFFFAAAAAAAA;
        saxi_wstrb = 8'h0F;
        saxi_wvalid = 1'b1;
        tick();
        saxi_wvalid = 1'b0;
        chk("t2_wready_low", 64'(saxi_wready), 64'h0);
        chk("t2_awready_high", 64'(saxi_awready), 64'h1);
        tick();
        tick();
        chk("t2_reg2_before", reg_of(2), 64'h0);
        chk("t2_no_bvalid", 64'(saxi_bvalid), 64'h0);
        saxi_awaddr = 64'h10;
        saxi_awvalid = 1'b1;
        bq.push_back(2'b00);
        tick();
        saxi_awvalid = 1'b0;
        chk("t2_bvalid", 64'(saxi_bvalid), 64'h1);
        chk("t2_reg2", reg_of(2), 64'h00000000AAAAAAAA);
        chk("t2_pulse", 64'(reg_wr_pulse), 64'h0004);

        // B back-pressure with a new AW waiting
        saxi_awaddr = 64'h18;
        saxi_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_bvalid", 64'(saxi_bvalid), 64'h1);
            chk("t3_bresp", 64'(saxi_bresp), 64'h0);
            chk("t3_awready", 64'(saxi_awready), 64'h0);
            chk("t3_wready", 64'(saxi_wready), 64'h0);
            tick();
        end
        saxi_bready = 1'b1;
        tick();
        saxi_bready = 1'b0;
        chk("t3_awready_after", 64'(saxi_awready), 64'h1);
        chk("t3_bvalid_drop", 64'(saxi_bvalid), 64'h0);
        saxi_wdata = 64'h0000000000000055;
        saxi_wstrb = 8'h01;
        saxi_wvalid = 1'b1;
        bq.push_back(2'b00);
        tick();
        saxi_awvalid = 1'b0;
        saxi_wvalid = 1'b0;
        chk("t3_reg3", reg_of(3), 64'h55);
        chk("t3_pulse", 64'(reg_wr_pulse), 64'h0008);
        saxi_bready = 1'b1;
        tick();
        saxi_bready = 1'b0;

        // Out-of-range read and write at 0x80
        snap = reg_out;
        saxi_araddr = 64'h80;
        saxi_arvalid = 1'b1;
        saxi_rready = 1'b1;
        rq.push_back('{resp: 2'b10, data: 64'h0});
        tick();
        saxi_arvalid = 1'b0;
        chk("t4_rvalid", 64'(saxi_rvalid), 64'h1);
        tick();
        saxi_rready = 1'b0;
        chk("t4_rvalid_drop", 64'(saxi_rvalid), 64'h0);
        saxi_awaddr = 64'h80;
        saxi_awvalid = 1'b1;
        saxi_wdata = '1;
        saxi_wstrb = 8'hFF;
        saxi_wvalid = 1'b1;
        bq.push_back(2'b10);
        tick();
        saxi_awvalid = 1'b0;
        saxi_wvalid = 1'b0;
        chk("t4_bresp", 64'(saxi_bresp), 64'h2);
        chk("t4_pulse", 64'(reg_wr_pulse), 64'h0);
        chk_regs("t4_regs", snap);
        saxi_bready = 1'b1;
        tick();
        saxi_bready = 1'b0;
        chk_regs("t4_regs_after", snap);

        // Read and write of reg1 on the same edge
        saxi_awaddr = 64'h08;
        saxi_awvalid = 1'b1;
        saxi_wdata = 64'hDEADBEEFCAFEF00D;
        saxi_wstrb = 8'hF0;
        saxi_wvalid = 1'b1;
        saxi_araddr = 64'h08;
        saxi_arvalid = 1'b1;
        bq.push_back(2'b00);
        rq.push_back('{resp: 2'b00, data: 64'h1122334455667788});
        tick();
        saxi_awvalid = 1'b0;
        saxi_wvalid = 1'b0;
        saxi_arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_rvalid_hold", 64'(saxi_rvalid), 64'h1);
            chk("t5_rdata_hold", saxi_rdata, 64'h1122334455667788);
            chk("t5_arready", 64'(saxi_arready), 64'h0);
            tick();
        end
        chk("t5_reg1_new", reg_of(1), 64'hDEADBEEF55667788);
        saxi_rready = 1'b1;
        saxi_bready = 1'b1;
        tick();
        saxi_rready = 1'b0;
        saxi_bready = 1'b0;
        saxi_araddr = 64'h0D;
        saxi_arvalid = 1'b1;
        saxi_rready = 1'b1;
        rq.push_back('{resp: 2'b00, data: 64'hDEADBEEF55667788});
        tick();
        saxi_arvalid = 1'b0;
        tick();
        saxi_rready = 1'b0;

        // Async reset with both responses pending
        saxi_awaddr = 64'h00;
        saxi_awvalid = 1'b1;
        saxi_wdata = 64'h0123;
        saxi_wstrb = 8'hFF;
        saxi_wvalid = 1'b1;
        saxi_araddr = 64'h00;
        saxi_arvalid = 1'b1;
        tick();
        saxi_awvalid = 1'b0;
        saxi_wvalid = 1'b0;
        saxi_arvalid = 1'b0;
        chk("t6_bvalid_pre", 64'(saxi_bvalid), 64'h1);
        chk("t6_rvalid_pre", 64'(saxi_rvalid), 64'h1);
        #1;
        axi_arst = 1'b1;
        #1;
        chk("t6_bvalid_rst", 64'(saxi_bvalid), 64'h0);
        chk("t6_rvalid_rst", 64'(saxi_rvalid), 64'h0);
        chk("t6_rdata_rst", saxi_rdata, 64'h0);
        chk("t6_pulse_rst", 64'(reg_wr_pulse), 64'h0);
        chk_regs("t6_regs_rst", '0);
        tick();
        axi_arst = 1'b0;
        tick();
        saxi_awaddr = 64'h20;
        saxi_awvalid = 1'b1;
        saxi_wdata = 64'hCAFE0000BEEF1234;
        saxi_wstrb = 8'hFF;
        saxi_wvalid = 1'b1;
        bq.push_back(2'b00);
        tick();
        saxi_awvalid = 1'b0;
        saxi_wvalid = 1'b0;
        chk("t6_reg4", reg_of(4), 64'hCAFE0000BEEF1234);
        saxi_bready = 1'b1;
        tick();
        saxi_bready = 1'b0;
        saxi_araddr = 64'h20;
        saxi_arvalid = 1'b1;
        saxi_rready = 1'b1;
        rq.push_back('{resp: 2'b00, data: 64'hCAFE0000BEEF1234});
        tick();
        saxi_arvalid = 1'b0;
        tick();
        saxi_rready = 1'b0;
        tick();

        chk("bq_drained", 64'(bq.size()), 64'h0);
        chk("rq_drained", 64'(rq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
